// File: rtl/csr_exec_unit.sv
// csr_exec_unit: EX-stage CSRRW/RS/RC(+I) execute with a one-entry EX/WB result register.
// Old CSR value is locally forwarded from the held result so a stalled WB never exposes stale data.
module csr_exec_unit #(
   parameter int CSR_ADDR_WIDTH = 12,
   parameter int XLEN = 32
) (
   input  logic                      clk_in,
   input  logic                      reset_in,
   input  logic                      valid_in,
   output logic                      ready_out,
   input  logic [2:0]                op_in,
   input  logic [CSR_ADDR_WIDTH-1:0] csr_addr_in,
   input  logic [4:0]                rs1_idx_in,
   input  logic [XLEN-1:0]           rs1_data_in,
   input  logic [4:0]                rd_idx_in,
   output logic [CSR_ADDR_WIDTH-1:0] raddr_out,
   input  logic [XLEN-1:0]           rdata_in,
   input  logic                      flush_in,
   output logic                      valid_out,
   input  logic                      ready_in,
   output logic [4:0]                rd_idx_out,
   output logic                      rd_we_out,
   output logic [XLEN-1:0]           rd_wdata_out,
   output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_out,
   output logic [XLEN-1:0]           csr_wdata_out,
   output logic                      csr_we_out,
   output logic                      illegal_out,
   output logic                      instret_incr_out
);
   logic                      valid_q, valid_d, wr_q, wr_d, ill_q, ill_d, rd_we_q, rd_we_d;
   logic [4:0]                rd_idx_q, rd_idx_d;
   logic [XLEN-1:0]           rd_wdata_q, rd_wdata_d, csr_wdata_q, csr_wdata_d;
   logic [CSR_ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [XLEN-1:0]           src, old, nv;
   logic                      wr_int, ill, accept;

   assign ready_out        = !valid_q || ready_in;
   assign raddr_out        = csr_addr_in;
   assign valid_out        = valid_q;
   assign rd_idx_out       = rd_idx_q;
   assign rd_we_out        = rd_we_q;
   assign rd_wdata_out     = rd_wdata_q;
   assign csr_waddr_out    = waddr_q;
   assign csr_wdata_out    = csr_wdata_q;
   assign illegal_out      = ill_q;
   assign csr_we_out       = valid_q && wr_q && ready_in && !flush_in;
   assign instret_incr_out = valid_q && ready_in && !flush_in && !ill_q;

   always_comb begin
      src         = op_in[2] ? XLEN'(rs1_idx_in) : rs1_data_in;
      wr_int      = (op_in[1:0] == 2'b01) || (rs1_idx_in != 5'd0);
      ill         = (op_in[1:0] == 2'b00) || (wr_int && csr_addr_in[CSR_ADDR_WIDTH-1 -: 2] == 2'b11);
      old         = (valid_q && wr_q && waddr_q == csr_addr_in) ? csr_wdata_q : rdata_in;
      nv          = (op_in[1:0] == 2'b01) ? src : (op_in[1:0] == 2'b10) ? (old | src) : (old & ~src);
      accept      = valid_in && ready_out && !flush_in;
      valid_d     = accept || (valid_q && !ready_in && !flush_in);
      // Illegal results are captured with every side effect suppressed.
      wr_d        = accept ? (wr_int && !ill) : wr_q;
      ill_d       = accept ? ill : ill_q;
      rd_we_d     = accept ? (!ill && rd_idx_in != 5'd0) : rd_we_q;
      rd_idx_d    = accept ? rd_idx_in : rd_idx_q;
      rd_wdata_d  = accept ? (ill ? '0 : old) : rd_wdata_q;
      csr_wdata_d = accept ? (ill ? '0 : nv) : csr_wdata_q;
      waddr_d     = accept ? csr_addr_in : waddr_q;
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         valid_q     <= 1'b0;
         wr_q        <= 1'b0;
         ill_q       <= 1'b0;
         rd_we_q     <= 1'b0;
         rd_idx_q    <= '0;
         rd_wdata_q  <= '0;
         csr_wdata_q <= '0;
         waddr_q     <= '0;
      end else begin
         valid_q     <= valid_d;
         wr_q        <= wr_d;
         ill_q       <= ill_d;
         rd_we_q     <= rd_we_d;
         rd_idx_q    <= rd_idx_d;
         rd_wdata_q  <= rd_wdata_d;
         csr_wdata_q <= csr_wdata_d;
         waddr_q     <= waddr_d;
      end
   end
endmodule

// File: tb/tb_csr_exec_unit.sv
// tb_csr_exec_unit: directed vector table, hand-written stall/flush/reset sequences,
// and randomized traffic against an architectural-vs-file CSR model.
module tb_csr_exec_unit;
   logic        clk_in = 1'b0, reset_in = 1'b1, valid_in = 1'b0, flush_in = 1'b0, ready_in = 1'b0;
   logic [2:0]  op_in = '0;
   logic [11:0] csr_addr_in = '0;
   logic [4:0]  rs1_idx_in = '0, rd_idx_in = '0;
   logic [31:0] rs1_data_in = '0, rdata_in = '0;
   logic        ready_out, valid_out, rd_we_out, csr_we_out, illegal_out, instret_incr_out;
   logic [11:0] raddr_out, csr_waddr_out;
   logic [4:0]  rd_idx_out;
   logic [31:0] rd_wdata_out, csr_wdata_out;

   csr_exec_unit dut (
      .clk_in(clk_in), .reset_in(reset_in), .valid_in(valid_in), .ready_out(ready_out),
      .op_in(op_in), .csr_addr_in(csr_addr_in), .rs1_idx_in(rs1_idx_in), .rs1_data_in(rs1_data_in),
      .rd_idx_in(rd_idx_in), .raddr_out(raddr_out), .rdata_in(rdata_in), .flush_in(flush_in),
      .valid_out(valid_out), .ready_in(ready_in), .rd_idx_out(rd_idx_out), .rd_we_out(rd_we_out),
      .rd_wdata_out(rd_wdata_out), .csr_waddr_out(csr_waddr_out), .csr_wdata_out(csr_wdata_out),
      .csr_we_out(csr_we_out), .illegal_out(illegal_out), .instret_incr_out(instret_incr_out)
   );

   always #5 clk_in = ~clk_in;

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic put(input logic [2:0] op, input logic [11:0] a, input logic [4:0] rs1,
                      input logic [31:0] d, input logic [4:0] rd, input logic [31:0] rdat);
      op_in = op; csr_addr_in = a; rs1_idx_in = rs1; rs1_data_in = d; rd_idx_in = rd; rdata_in = rdat;
   endtask

   typedef struct {
      logic [2:0] op; logic [11:0] addr; logic [4:0] rs1; logic [31:0] data; logic [4:0] rd;
      logic [31:0] rdata; logic ill; logic rd_we; logic [31:0] rd_wdata; logic csr_we; logic [31:0] csr_wdata;
   } vec_t;
   vec_t vecs[13];

   logic [31:0] file_m[4096], arch_m[4096];
   logic        m_valid, m_wr, m_ill, m_rd_we;
   logic [4:0]  m_rd;
   logic [11:0] m_addr;
   logic [31:0] m_new, m_rdw;
   logic [2:0]  ops[8] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7, 3'd0, 3'd4};
   logic [11:0] pool[6] = '{12'h340, 12'h341, 12'h300, 12'hF11, 12'hC00, 12'h305};

   initial begin
      vecs[0]  = '{3'b001, 12'h340, 5'd5,  32'hDEADBEEF, 5'd6, 32'h12345678, 1'b0, 1'b1, 32'h12345678, 1'b1, 32'hDEADBEEF};
      vecs[1]  = '{3'b010, 12'h300, 5'd0,  32'hFFFFFFFF, 5'd7, 32'h00001800, 1'b0, 1'b1, 32'h00001800, 1'b0, 32'h0};
      vecs[2]  = '{3'b111, 12'h340, 5'd3,  32'h0,        5'd1, 32'h0000000F, 1'b0, 1'b1, 32'h0000000F, 1'b1, 32'h0000000C};
      vecs[3]  = '{3'b001, 12'hF11, 5'd2,  32'h0000AAAA, 5'd9, 32'h00001234, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
      vecs[4]  = '{3'b010, 12'hF11, 5'd0,  32'h0,        5'd8, 32'h00000489, 1'b0, 1'b1, 32'h00000489, 1'b0, 32'h0};
      vecs[5]  = '{3'b000, 12'h340, 5'd1,  32'h5,        5'd3, 32'h00000077, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
      vecs[6]  = '{3'b100, 12'h340, 5'd0,  32'h5,        5'd3, 32'h00000077, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
      vecs[7]  = '{3'b001, 12'h341, 5'd4,  32'h0000CAFE, 5'd0, 32'h00000055, 1'b0, 1'b0, 32'h00000055, 1'b1, 32'h0000CAFE};
      vecs[8]  = '{3'b110, 12'h341, 5'd16, 32'h0,        5'd2, 32'h00000001, 1'b0, 1'b1, 32'h00000001, 1'b1, 32'h00000011};
      vecs[9]  = '{3'b011, 12'h305, 5'd3,  32'h00000F0F, 5'd4, 32'h0000FFFF, 1'b0, 1'b1, 32'h0000FFFF, 1'b1, 32'h0000F0F0};
      vecs[10] = '{3'b101, 12'hC00, 5'd1,  32'h0,        5'd5, 32'h00000009, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
      vecs[11] = '{3'b110, 12'hC00, 5'd0,  32'h0,        5'd5, 32'h00000009, 1'b0, 1'b1, 32'h00000009, 1'b0, 32'h0};
      vecs[12] = '{3'b011, 12'h340, 5'd0,  32'hFFFFFFFF, 5'd6, 32'h0000ABCD, 1'b0, 1'b1, 32'h0000ABCD, 1'b0, 32'h0};

      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      reset_in = 1'b0;
      #1;
      chk("rst_valid", valid_out, 0);
      chk("rst_illegal", illegal_out, 0);
      chk("rst_rd_we", rd_we_out, 0);
      chk("rst_rd_idx", rd_idx_out, 0);
      chk("rst_rd_wdata", rd_wdata_out, 0);
      chk("rst_csr_waddr", csr_waddr_out, 0);
      chk("rst_csr_wdata", csr_wdata_out, 0);
      chk("rst_ready", ready_out, 1);
      chk("rst_csr_we", csr_we_out, 0);
      chk("rst_instret", instret_incr_out, 0);

      ready_in = 1'b1;
      foreach (vecs[i]) begin
         @(negedge clk_in);
         put(vecs[i].op, vecs[i].addr, vecs[i].rs1, vecs[i].data, vecs[i].rd, vecs[i].rdata);
         valid_in = 1'b1;
         #1 chk($sformatf("v%0d_raddr", i), raddr_out, vecs[i].addr);
         @(negedge clk_in);
         valid_in = 1'b0;
         #1;
         chk($sformatf("v%0d_valid", i), valid_out, 1);
         chk($sformatf("v%0d_illegal", i), illegal_out, vecs[i].ill);
         chk($sformatf("v%0d_rd_we", i), rd_we_out, vecs[i].rd_we);
         chk($sformatf("v%0d_rd_wdata", i), rd_wdata_out, vecs[i].rd_wdata);
         chk($sformatf("v%0d_rd_idx", i), rd_idx_out, vecs[i].rd);
         chk($sformatf("v%0d_waddr", i), csr_waddr_out, vecs[i].addr);
         chk($sformatf("v%0d_csr_we", i), csr_we_out, vecs[i].csr_we);
         chk($sformatf("v%0d_instret", i), instret_incr_out, !vecs[i].ill);
         if (vecs[i].csr_we) chk($sformatf("v%0d_csr_wdata", i), csr_wdata_out, vecs[i].csr_wdata);
      end

      // Stall: second same-CSR read must see the held, unwritten value via local forward
      @(negedge clk_in);
      ready_in = 1'b0;
      valid_in = 1'b1;
      put(3'b101, 12'h340, 5'd7, 32'h0, 5'd1, 32'h55);
      @(negedge clk_in);
      put(3'b010, 12'h340, 5'd0, 32'h0, 5'd2, 32'h0);
      #1;
      chk("stall_ready", ready_out, 0);
      chk("stall_valid", valid_out, 1);
      chk("stall_csr_wdata", csr_wdata_out, 7);
      chk("stall_rd_wdata", rd_wdata_out, 32'h55);
      chk("stall_csr_we", csr_we_out, 0);
      repeat (2) begin
         @(negedge clk_in);
         #1;
         chk("stall_hold_rd_idx", rd_idx_out, 1);
         chk("stall_hold_wdata", csr_wdata_out, 7);
         chk("stall_hold_valid", valid_out, 1);
      end
      ready_in = 1'b1;
      #1;
      chk("release_csr_we", csr_we_out, 1);
      chk("release_instret", instret_incr_out, 1);
      chk("release_ready", ready_out, 1);
      @(negedge clk_in);
      valid_in = 1'b0;
      #1;
      chk("fwd_valid", valid_out, 1);
      chk("fwd_rd_idx", rd_idx_out, 2);
      chk("fwd_rd_wdata", rd_wdata_out, 7);
      chk("fwd_csr_we", csr_we_out, 0);

      // Flush beats consume and accept together
      valid_in = 1'b1;
      flush_in = 1'b1;
      put(3'b001, 12'h341, 5'd3, 32'h1234, 5'd4, 32'h0);
      #1;
      chk("flush_csr_we", csr_we_out, 0);
      chk("flush_instret", instret_incr_out, 0);
      @(negedge clk_in);
      flush_in = 1'b0;
      valid_in = 1'b0;
      #1 chk("flush_valid", valid_out, 0);

      // Asynchronous reset mid-stall
      ready_in = 1'b0;
      valid_in = 1'b1;
      put(3'b001, 12'h340, 5'd3, 32'h99, 5'd4, 32'h0);
      @(negedge clk_in);
      valid_in = 1'b0;
      #1 chk("arst_pre_valid", valid_out, 1);
      #1 reset_in = 1'b1;
      #1;
      chk("arst_valid", valid_out, 0);
      chk("arst_ready", ready_out, 1);
      #1 reset_in = 1'b0;
      ready_in = 1'b1;
      #1 chk("arst_csr_we", csr_we_out, 0);

      // Randomized traffic: arch_m is program-order CSR state, file_m is what WB has written.
      for (int a = 0; a < 4096; a++) begin
         file_m[a] = $urandom;
         arch_m[a] = file_m[a];
      end
      m_valid = 1'b0; m_wr = 1'b0; m_ill = 1'b0; m_rd_we = 1'b0;
      m_rd = '0; m_addr = '0; m_new = '0; m_rdw = '0;
      @(negedge clk_in);
      for (int c = 0; c < 3000; c++) begin
         chk("rnd_valid", valid_out, m_valid);
         if (m_valid) begin
            chk("rnd_illegal", illegal_out, m_ill);
            chk("rnd_rd_we", rd_we_out, m_rd_we);
            chk("rnd_rd_wdata", rd_wdata_out, m_rdw);
            chk("rnd_rd_idx", rd_idx_out, m_rd);
            chk("rnd_waddr", csr_waddr_out, m_addr);
            if (m_wr) chk("rnd_csr_wdata", csr_wdata_out, m_new);
         end
         valid_in = $urandom_range(0, 9) < 7;
         ready_in = $urandom_range(0, 9) < 7;
         put(ops[$urandom_range(0, 7)], pool[$urandom_range(0, 5)],
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom,
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), 32'h0);
         rdata_in = ($urandom_range(0, 1) == 1 && m_valid && m_wr && ready_in && m_addr == csr_addr_in)
                    ? m_new : file_m[csr_addr_in];
         #1;
         chk("rnd_ready", ready_out, !m_valid || ready_in);
         chk("rnd_csr_we", csr_we_out, m_valid && m_wr && ready_in);
         chk("rnd_instret", instret_incr_out, m_valid && ready_in && !m_ill);
         @(posedge clk_in);
         begin
            logic        acc, wr, ill;
            logic [31:0] src, old, nv;
            acc = valid_in && (!m_valid || ready_in);
            if (m_valid && ready_in) begin
               if (m_wr) file_m[m_addr] = m_new;
               m_valid = 1'b0;
            end
            if (acc) begin
               src = op_in[2] ? {27'b0, rs1_idx_in} : rs1_data_in;
               wr  = (op_in[1:0] == 2'b01) || (rs1_idx_in != 0);
               ill = (op_in[1:0] == 2'b00) || (wr && csr_addr_in[11:10] == 2'b11);
               old = arch_m[csr_addr_in];
               nv  = (op_in[1:0] == 2'b01) ? src : (op_in[1:0] == 2'b10) ? (old | src) : (old & ~src);
               m_valid = 1'b1;
               m_ill   = ill;
               m_wr    = wr && !ill;
               m_rd    = rd_idx_in;
               m_addr  = csr_addr_in;
               m_new   = nv;
               m_rd_we = !ill && rd_idx_in != 0;
               m_rdw   = ill ? 32'h0 : old;
               if (m_wr) arch_m[csr_addr_in] = nv;
            end
         end
         @(negedge clk_in);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/csr_exec_unit.md
# csr_exec_unit

EX-stage CSR instruction unit feeding the write-back CSR register file. It decodes CSRRW/CSRRS/CSRRC and their immediate forms, reads the old CSR value through the file's combinational read port, and computes the new CSR value and the rd result. Results are held in a one-entry EX/WB pipeline register with a valid/ready handshake. WB consumes that register and drives the file's write port and instret increment.

## Interface
- CSR_ADDR_WIDTH, 12: CSR address width.
- XLEN, 32: data width.
- clk_in  in  1  clock; all state updates on the rising edge.
- reset_in  in  1  reset, asynchronous, active-high.
- valid_in  in  1  a CSR instruction is presented.
- ready_out  out  1  unit accepts this cycle; ready_out = !valid_out || ready_in.
- op_in  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000/100 illegal.
- csr_addr_in  in  CSR_ADDR_WIDTH  target CSR.
- rs1_idx_in  in  5  rs1 index, or zimm for the I forms.
- rs1_data_in  in  XLEN  rs1 value; ignored for I forms.
- rd_idx_in  in  5  destination register.
- raddr_out  out  CSR_ADDR_WIDTH  CSR file read address; equals csr_addr_in, combinational.
- rdata_in  in  XLEN  CSR file read data, same cycle.
- flush_in  in  1  kill the held result and any presented instruction.
- valid_out  out  1  EX/WB register holds a result.
- ready_in  in  1  WB consumes the result when valid_out && ready_in.
- rd_idx_out  out  5  registered rd index.
- rd_we_out  out  1  registered; set when rd != 0 and not illegal.
- rd_wdata_out  out  XLEN  registered old CSR value; 0 when illegal.
- csr_waddr_out  out  CSR_ADDR_WIDTH  registered write address.
- csr_wdata_out  out  XLEN  registered new CSR value.
- csr_we_out  out  1  valid_out && wr_q && ready_in && !flush_in; a single-cycle write strobe per instruction.
- illegal_out  out  1  registered illegal-instruction flag.
- instret_incr_out  out  1  valid_out && ready_in && !flush_in && !illegal_q.

## Operation
- Source operand: src = op_in[2] ? {27'b0, rs1_idx_in} : rs1_data_in.
- Write intent:
  - RW/RWI always write.
  - RS/RC and RSI/RCI write only when rs1_idx_in != 0.
- Old value (local forward): old = (valid_out && wr_q && csr_waddr_out == csr_addr_in) ? csr_wdata_out : rdata_in.
  - This covers a stalled WB, where the CSR file bypass is inactive.
- New value:
  - RW: src.
  - RS: old | src.
  - RC: old & ~src.
  - All arithmetic is XLEN bits, no carries.
- Illegal when either holds:
  - op_in[1:0] == 00.
  - Write intent && csr_addr_in[11:10] == 2'b11 (read-only space).
- Illegal instructions are captured with illegal_q=1, wr_q=0, rd_we=0, rd_wdata=0.
- Pipeline register:
  - Loads on valid_in && ready_out && !flush_in.
  - Otherwise clears valid when consumed (valid_out && ready_in) or when flush_in is set.
  - Otherwise holds every field unchanged.
- Flush wins over accept and consume in the same cycle.
  - The next state is valid_out=0.
  - csr_we_out and instret_incr_out stay low that cycle.

## Timing
- Reset values: valid_out=0, illegal_out=0, rd_we_out=0, all data/address outputs 0, wr_q=0. ready_out=1 after reset.
- Latency: accepted at edge N; outputs valid after edge N, so WB can write at edge N+1 at the earliest.
- Throughput: one instruction per cycle while ready_in=1.
  - Simultaneous consume and accept reloads the register on the same edge.
- Stall: with ready_in=0 and valid_out=1, ready_out=0.
  - Outputs are stable; valid_in is ignored.
- Back-to-back same CSR: the second instruction sees the first one's new value, whether or not WB has written it yet.
  - If WB is writing, the file's bypass supplies it.
  - If WB is stalled, the local forward supplies it.
- Reset asserted mid-stall clears valid_out immediately (asynchronously); no write strobe follows.

## Test plan
- Reset, then CSRRW mscratch(0x340), rs1=x5=0xDEADBEEF, rd=x6, old value 0x12345678 -> next cycle valid_out=1, csr_wdata_out=0xDEADBEEF, rd_wdata_out=0x12345678, rd_we_out=1, csr_we_out=1 with ready_in=1.
- CSRRS mstatus(0x300) with rs1_idx=0 -> csr_we_out never asserts, rd_wdata_out=old; CSRRCI zimm=0x3 on old 0xF -> csr_wdata_out=0xC.
- CSRRW to mvendorid(0xF11) -> illegal_out=1, csr_we_out=0, instret_incr_out=0; CSRRS to 0xF11 with rs1_idx=0 -> legal read.
- Hold ready_in=0: CSRRWI 0x340 zimm=7, then CSRRS 0x340 rs1=x0 held on the input (rdata_in stale 0) -> after release, second instruction's rd_wdata_out=7.
- Assert flush_in while valid_out=1 and valid_in=1 -> valid_out=0 next cycle; no csr_we_out or instret_incr_out pulse.
- Async reset pulse between edges while valid_out=1 -> valid_out drops without a clock edge; ready_out=1.
